sort_result_serializer: RTL

SORT_RESULT_SERIALIZER -- requirements
Module: sort_result_serializer

---
 rtl/sort_result_serializer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sort_result_serializer.sv
// Streams a captured sorted vector one element per accepted beat over a valid/ready port.
// Optional adjacent-element order checker enabled by macro SORT_SER_ORDER_CHECK_EN.
module sort_result_serializer #(
    parameter int unsigned LOG_INPUT  = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SIGNED     = 0,
    parameter int unsigned ASCENDING  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 x_valid,
    input  logic [DATA_WIDTH*(2**LOG_INPUT)-1:0] x,
    output logic [DATA_WIDTH-1:0]                m_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic                                 m_last,
    output logic [LOG_INPUT-1:0]                 m_index,
    output logic                                 busy,
    output logic                                 overflow,
    output logic                                 order_err
);

    localparam int unsigned N     = 2 ** LOG_INPUT;
    localparam int unsigned VEC_W = DATA_WIDTH * N;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    localparam logic [LOG_INPUT-1:0] LAST_IDX = LOG_INPUT'(N - 1);

    logic [0:0]            state_q,    state_d;
    logic [VEC_W-1:0]      hold_q,     hold_d;
    logic [LOG_INPUT-1:0]  idx_q,      idx_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] m_data_q,   m_data_d;
    logic                  m_valid_q,  m_valid_d;
    logic                  m_last_q,   m_last_d;
    logic                  busy_q,     busy_d;

    logic xfer_c;
    logic xfer_last_c;

    assign xfer_c      = (state_q == STREAM) && m_ready;
    assign xfer_last_c = xfer_c && (idx_q == LAST_IDX);

    // Next-state, holding register, index and overflow tracking
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (x_valid) begin
                    hold_d  = x;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (xfer_last_c) begin
                    idx_d = '0;
                    if (x_valid) begin
                        // Refill on the last beat so the stream continues without a bubble
                        hold_d = x;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer_c) begin
                        idx_d = idx_q + LOG_INPUT'(1);
                    end
                    if (x_valid) begin
                        overflow_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Output registers derived from the next state so outputs change with the state
    always_comb begin
        m_valid_d = (state_d == STREAM);
        busy_d    = (state_d == STREAM);
        m_last_d  = 1'b0;
        m_data_d  = '0;
        if (state_d == STREAM) begin
            m_last_d = (idx_d == LAST_IDX);
            m_data_d = hold_d[DATA_WIDTH * 32'(idx_d) +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            busy_q     <= busy_d;
        end
    end

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign m_index  = idx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

`ifdef SORT_SER_ORDER_CHECK_EN
    logic [DATA_WIDTH-1:0] prev_q,      prev_d;
    logic                  order_err_q, order_err_d;
    logic                  lt_c;
    logic                  gt_c;
    logic                  viol_c;

    always_comb begin
        if (SIGNED != 0) begin
            lt_c = $signed(m_data_q) < $signed(prev_q);
            gt_c = $signed(m_data_q) > $signed(prev_q);
        end else begin
            lt_c = m_data_q < prev_q;
            gt_c = m_data_q > prev_q;
        end
        viol_c = (ASCENDING != 0) ? lt_c : gt_c;
    end

    // Compare each non-first beat of a vector against the previously accepted beat
    always_comb begin
        prev_d      = prev_q;
        order_err_d = order_err_q;
        if (xfer_c) begin
            prev_d = m_data_q;
            if ((idx_q != '0) && viol_c) begin
                order_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q      <= '0;
            order_err_q <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            order_err_q <= order_err_d;
        end
    end

    assign order_err = order_err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{SIGNED[0], ASCENDING[0]};
    assign order_err  = 1'b0;
`endif

endmodule
